uart_cmd_ctrl: RTL and testbench
================================

// Module: uart_cmd_ctrl
// PURPOSE
//  Sequences the byte stream from the UART receiver into register-write commands.
//  Frame format: HDR_BYTE, ADDR, DATA, then CHK when the checksum option is compiled in.
//  Issues one write per valid frame on a req/ack handshake.
//  Flags timeout, checksum and overrun errors. Sits between uart_recv and the register file.
// PARAMETERS
//  HDR_BYTE     8'hA5     frame start marker
//  TIMEOUT_CNT  16'd21700 max sys_clk cycles between bytes inside a frame (~5 byte times @115200, 50MHz)
// PORTS
//  sys_clk       in   1   system clock, 50MHz
//  sys_rst_n     in   1   asynchronous reset, active-low
//  rx_byte_done  in   1   receiver done flag; level, high for many cycles per byte
//  rx_data       in   8   received byte; valid while rx_byte_done=1
//  reg_wr_req    out  1   write request, held until acked
//  reg_addr      out  8   write address, stable while reg_wr_req=1
//  reg_wdata     out  8   write data, stable while reg_wr_req=1
//  reg_wr_ack    in   1   1-cycle write accept from the register file
//  frame_err     out  1   1-cycle error pulse
//  err_code      out  2   01 timeout, 10 checksum, 11 overrun; holds until the next error
//  busy          out  1   high in any state other than IDLE
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0; internal counters/registers 0. Reset mid-frame aborts with no error.
//  Byte event: byte_evt = rx_byte_done & ~done_d (rising edge). Capture rx_data in the same cycle.
//    Exactly one event per byte, however long rx_byte_done stays high.
//  FSM:
//    IDLE  -> ADDR on byte_evt with data==HDR_BYTE. Any other byte is ignored silently, no error.
//    ADDR  -> DATA on byte_evt; latch addr.
//    DATA  -> CHK (option on) or WRITE (option off) on byte_evt; latch data.
//    CHK   -> WRITE on byte_evt if byte==addr^data; else IDLE with checksum error.
//    WRITE -> IDLE on reg_wr_ack.
//  Write output: reg_wr_req rises the cycle after entering WRITE and drops the cycle after reg_wr_ack.
//    Latency: last frame byte event -> reg_wr_req=1 in 1 cycle.
//  Timeout: tmo_cnt clears on every byte_evt and counts in ADDR/DATA/CHK.
//    When tmo_cnt==TIMEOUT_CNT-1: go to IDLE, frame_err=1, err_code=01.
//    byte_evt in the same cycle wins: counter clears, no timeout.
//  Overrun: byte_evt in WRITE without reg_wr_ack: drop the byte, frame_err=1, err_code=11, stay in WRITE.
//    byte_evt together with reg_wr_ack: the write completes; the byte is evaluated as an IDLE header candidate.
//  No timeout is applied in WRITE; the register file must eventually ack.
//  tmo_cnt saturates at TIMEOUT_CNT-1 and never wraps.
// CONFIGURATION
//  UART_CMD_CHKSUM_EN defined: 4-byte frame; CHK state present; checksum error (10) possible.
//  UART_CMD_CHKSUM_EN undefined: 3-byte frame; CHK state removed; err_code 10 never occurs.
// STRUCTURE
//  Shared include uart_defs.vh holds:
//    state encodings (IDLE=0, ADDR=1, DATA=2, CHK=3, WRITE=4)
//    err_code constants ERR_TMO, ERR_CHK, ERR_OVR
//    default HDR_BYTE
//  One sub-module: uart_byte_timer, containing the tmo_cnt counter (clr, en, expire pulse). FSM and datapath stay in the top.
// TESTING
//  Bench drives rx_byte_done/rx_data with 200-cycle done pulses, or instantiates uart_recv.
//  Frame A5,12,34 (+26 with option on), ack 3 cycles after req
//    -> reg_addr=12, reg_wdata=34, req high 4 cycles, no frame_err.
//  Option on: frame A5,12,34,00 -> frame_err pulse, err_code=10, no reg_wr_req, back to IDLE.
//  A5,12, then 21700 idle cycles -> frame_err at cycle 21700 after the 12 event, err_code=01, busy=0.
//  Bytes 00,FF,A5,01,02(,03) -> only one write: addr 01, data 02; leading bytes ignored.
//  Hold ack low in WRITE and send byte 55 -> err_code=11, req stays high, addr/data unchanged.
//  Assert sys_rst_n=0 mid-frame (after A5,12) -> all outputs 0 immediately; next full frame is accepted.

Source files
------------

// File: rtl/uart_cmd_ctrl_pkg.sv
// uart_cmd_ctrl_pkg: FSM state encodings, error codes and default frame constants.
package uart_cmd_ctrl_pkg;
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ADDR  = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_CHK   = 3'd3;
  localparam logic [2:0] S_WRITE = 3'd4;
  localparam logic [1:0] ERR_TMO = 2'b01;
  localparam logic [1:0] ERR_CHK = 2'b10;
  localparam logic [1:0] ERR_OVR = 2'b11;
  localparam logic [7:0] HDR_BYTE_DEF = 8'hA5;
  localparam logic [15:0] TIMEOUT_CNT_DEF = 16'd21700;
endpackage

// File: rtl/uart_cmd_ctrl_byte_timer.sv
// uart_cmd_ctrl_byte_timer: inter-byte timeout counter; saturates and pulses o_expire at TIMEOUT_CNT-1.
module uart_cmd_ctrl_byte_timer #(
  parameter logic [15:0] TIMEOUT_CNT = 16'd21700
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expire
);
  localparam logic [15:0] MAX = TIMEOUT_CNT - 16'd1;
  logic [15:0] r_cnt;
  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) r_cnt <= '0;
    else r_cnt <= i_clr ? '0 : (i_en && r_cnt != MAX) ? r_cnt + 16'd1 : r_cnt;
  // a byte arriving on the expiry cycle wins over the timeout
  assign o_expire = i_en & ~i_clr & (r_cnt == MAX);
endmodule

// File: rtl/uart_cmd_ctrl.sv
// uart_cmd_ctrl: turns UART bytes (HDR, ADDR, DATA[, CHK]) into req/ack register writes.
// Define UART_CMD_CHKSUM_EN to require the trailing ADDR^DATA checksum byte.
module uart_cmd_ctrl
  import uart_cmd_ctrl_pkg::*;
#(
  parameter logic [7:0]  HDR_BYTE    = HDR_BYTE_DEF,
  parameter logic [15:0] TIMEOUT_CNT = TIMEOUT_CNT_DEF
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       i_rx_byte_done,
  input  logic [7:0] i_rx_data,
  output logic       o_reg_wr_req,
  output logic [7:0] o_reg_addr,
  output logic [7:0] o_reg_wdata,
  input  logic       i_reg_wr_ack,
  output logic       o_frame_err,
  output logic [1:0] o_err_code,
  output logic       o_busy
);
  logic [2:0] r_state, w_next;
  logic [7:0] r_addr, r_wdata;
  logic [1:0] r_err_code, w_code;
  logic       r_done_d, r_frame_err, w_evt, w_hdr, w_en, w_expire, w_err;

  assign w_evt = i_rx_byte_done & ~r_done_d;
  assign w_hdr = w_evt && i_rx_data == HDR_BYTE;
  assign w_en  = r_state == S_ADDR || r_state == S_DATA || r_state == S_CHK;

  uart_cmd_ctrl_byte_timer #(.TIMEOUT_CNT(TIMEOUT_CNT)) u_timer (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .i_clr    (w_evt),
    .i_en     (w_en),
    .o_expire (w_expire)
  );

  always_comb begin
    w_next = r_state;
    w_err  = 1'b0;
    w_code = ERR_TMO;
    case (r_state)
      S_IDLE: w_next = w_hdr ? S_ADDR : S_IDLE;
      S_ADDR: begin
        if (w_evt) w_next = S_DATA;
        else if (w_expire) begin w_next = S_IDLE; w_err = 1'b1; end
      end
      S_DATA: begin
`ifdef UART_CMD_CHKSUM_EN
        if (w_evt) w_next = S_CHK;
`else
        if (w_evt) w_next = S_WRITE;
`endif
        else if (w_expire) begin w_next = S_IDLE; w_err = 1'b1; end
      end
`ifdef UART_CMD_CHKSUM_EN
      S_CHK: begin
        if (w_evt && i_rx_data == (r_addr ^ r_wdata)) w_next = S_WRITE;
        else if (w_evt) begin w_next = S_IDLE; w_err = 1'b1; w_code = ERR_CHK; end
        else if (w_expire) begin w_next = S_IDLE; w_err = 1'b1; end
      end
`endif
      // a byte landing with the ack is treated as a fresh header candidate
      S_WRITE: begin
        if (i_reg_wr_ack) w_next = w_hdr ? S_ADDR : S_IDLE;
        else if (w_evt) begin w_err = 1'b1; w_code = ERR_OVR; end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) begin
      r_state     <= S_IDLE;
      r_done_d    <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_frame_err <= 1'b0;
      r_err_code  <= '0;
    end else begin
      r_state     <= w_next;
      r_done_d    <= i_rx_byte_done;
      r_addr      <= (r_state == S_ADDR && w_evt) ? i_rx_data : r_addr;
      r_wdata     <= (r_state == S_DATA && w_evt) ? i_rx_data : r_wdata;
      r_frame_err <= w_err;
      r_err_code  <= w_err ? w_code : r_err_code;
    end

  assign o_reg_wr_req = r_state == S_WRITE;
  assign o_reg_addr   = r_addr;
  assign o_reg_wdata  = r_wdata;
  assign o_frame_err  = r_frame_err;
  assign o_err_code   = r_err_code;
  assign o_busy       = r_state != S_IDLE;
endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// tb_uart_cmd_ctrl: directed frames against a frame-level model checked every cycle.
module tb_uart_cmd_ctrl;
`ifdef UART_CMD_CHKSUM_EN
  localparam int LEN = 4;
`else
  localparam int LEN = 3;
`endif
  localparam int TMO = 21700;

  logic sys_clk = 1'b0, sys_rst_n = 1'b0;
  logic done = 1'b0, ack = 1'b0;
  logic [7:0] data = 8'h00;
  logic req, ferr, busy;
  logic [7:0] addr, wdata;
  logic [1:0] code;

  int checks = 0, errors = 0;

  uart_cmd_ctrl dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .i_rx_byte_done(done), .i_rx_data(data),
    .o_reg_wr_req(req), .o_reg_addr(addr), .o_reg_wdata(wdata),
    .i_reg_wr_ack(ack), .o_frame_err(ferr), .o_err_code(code), .o_busy(busy)
  );

  always #10 sys_clk = ~sys_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // frame-level model: collected bytes, pending write, idle cycles since last byte
  logic [7:0] fb [0:3];
  int   m_n = 0, m_idle = 0;
  logic m_prev = 0, m_pend = 0, m_err = 0, m_evt;
  logic [7:0] m_addr = 0, m_data = 0;
  logic [1:0] m_code = 0;

  always @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) begin
      m_n = 0; m_idle = 0; m_prev = 0; m_pend = 0; m_err = 0; m_code = 0;
    end else begin
      m_evt = done && !m_prev;
      m_prev = done;
      m_err = 0;
      if (m_pend) begin
        if (ack) begin
          m_pend = 0;
          if (m_evt && data == 8'hA5) begin m_n = 1; m_idle = 0; end
        end else if (m_evt) begin m_err = 1; m_code = 2'b11; end
      end else if (m_n > 0) begin
        if (m_evt) begin
          fb[m_n] = data; m_n++; m_idle = 0;
          if (m_n == LEN) begin
            m_n = 0;
`ifdef UART_CMD_CHKSUM_EN
            if (data == (fb[1] ^ fb[2])) begin m_pend = 1; m_addr = fb[1]; m_data = fb[2]; end
            else begin m_err = 1; m_code = 2'b10; end
`else
            m_pend = 1; m_addr = fb[1]; m_data = fb[2];
`endif
          end
        end else begin
          m_idle++;
          if (m_idle == TMO) begin m_n = 0; m_err = 1; m_code = 2'b01; end
        end
      end else if (m_evt && data == 8'hA5) begin m_n = 1; m_idle = 0; end
    end

  always @(negedge sys_clk)
    if (sys_rst_n) begin
      chk("req", req, m_pend);
      chk("busy", busy, m_pend || m_n > 0);
      chk("frame_err", ferr, m_err);
      chk("err_code", code, m_code);
      if (m_pend) begin
        chk("addr", addr, m_addr);
        chk("wdata", wdata, m_data);
      end
    end

  // register-file responder: ack ack_dly cycles after req rises
  int ack_dly = 3, rcnt = 0;
  logic ack_en = 1;
  always @(posedge sys_clk) begin
    #1;
    rcnt = req ? rcnt + 1 : 0;
    ack = ack_en && req && rcnt >= ack_dly + 1;
  end

  int writes = 0, req_cyc = 0, err_pulses = 0;
  logic req_prev = 0;
  logic [7:0] wr_addr = 0, wr_data = 0;
  always @(negedge sys_clk) begin
    if (req && !req_prev) begin writes++; wr_addr = addr; wr_data = wdata; end
    if (req) req_cyc++;
    if (ferr) err_pulses++;
    req_prev = req;
  end

  task automatic send_byte(input logic [7:0] b);
    @(posedge sys_clk); #1 done = 1; data = b;
    repeat (200) @(posedge sys_clk);
    #1 done = 0;
    repeat (10) @(posedge sys_clk);
  endtask

  task automatic send_frame(input logic [7:0] a, input logic [7:0] d);
    send_byte(8'hA5); send_byte(a); send_byte(d);
`ifdef UART_CMD_CHKSUM_EN
    send_byte(a ^ d);
`endif
  endtask

  int w0, e0, k;
  initial begin
    #5;
    chk("rst_req", req, 0); chk("rst_busy", busy, 0); chk("rst_ferr", ferr, 0);
    chk("rst_code", code, 0); chk("rst_addr", addr, 0); chk("rst_wdata", wdata, 0);
    repeat (3) @(negedge sys_clk);
    sys_rst_n = 1;
    // basic frame
    w0 = writes; e0 = err_pulses; req_cyc = 0;
    send_frame(8'h12, 8'h34);
    @(negedge sys_clk);
    chk("f1_writes", writes - w0, 1); chk("f1_addr", wr_addr, 8'h12);
    chk("f1_data", wr_data, 8'h34); chk("f1_req_cycles", req_cyc, 4);
    chk("f1_no_err", err_pulses - e0, 0);
`ifdef UART_CMD_CHKSUM_EN
    w0 = writes; e0 = err_pulses;
    send_byte(8'hA5); send_byte(8'h12); send_byte(8'h34); send_byte(8'h00);
    @(negedge sys_clk);
    chk("chk_err", err_pulses - e0, 1); chk("chk_code", code, 2'b10);
    chk("chk_no_write", writes - w0, 0); chk("chk_idle", busy, 0);
`endif
    // timeout after the address byte
    send_byte(8'hA5);
    @(posedge sys_clk); #1 done = 1; data = 8'h12;
    k = -1;
    @(posedge sys_clk);
    do begin @(negedge sys_clk); k++; end while (!ferr && k < 22000);
    chk("tmo_cycle", k, TMO); chk("tmo_code", code, 2'b01);
    @(negedge sys_clk);
    chk("tmo_busy", busy, 0);
    done = 0;
    repeat (10) @(posedge sys_clk);
    // junk before header
    w0 = writes;
    send_byte(8'h00); send_byte(8'hFF); send_byte(8'hA5); send_byte(8'h01); send_byte(8'h02);
`ifdef UART_CMD_CHKSUM_EN
    send_byte(8'h03);
`endif
    @(negedge sys_clk);
    chk("junk_writes", writes - w0, 1); chk("junk_addr", wr_addr, 8'h01); chk("junk_data", wr_data, 8'h02);
    // overrun while the write is held
    ack_en = 0;
    send_frame(8'h12, 8'h34);
    send_byte(8'h55);
    @(negedge sys_clk);
    chk("ovr_code", code, 2'b11); chk("ovr_req", req, 1);
    chk("ovr_addr", addr, 8'h12); chk("ovr_data", wdata, 8'h34);
    ack_en = 1;
    repeat (5) @(negedge sys_clk);
    chk("ovr_done", req, 0);
    // reset mid-frame
    send_byte(8'hA5); send_byte(8'h12);
    @(posedge sys_clk); #3 sys_rst_n = 0;
    #1;
    chk("mid_rst_req", req, 0); chk("mid_rst_busy", busy, 0); chk("mid_rst_ferr", ferr, 0);
    chk("mid_rst_code", code, 0); chk("mid_rst_addr", addr, 0); chk("mid_rst_wdata", wdata, 0);
    @(negedge sys_clk); sys_rst_n = 1;
    w0 = writes;
    send_frame(8'h56, 8'h78);
    @(negedge sys_clk);
    chk("post_rst_writes", writes - w0, 1); chk("post_rst_addr", wr_addr, 8'h56);
    chk("post_rst_data", wr_data, 8'h78);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
